// File: rtl/opl3_pkg.sv
// Shared OPL3 types and register map constants.
// Holds the host register-write bus type and the timer/status register map.
package opl3_pkg;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    localparam logic [7:0] TIMER1_ADDR     = 8'h02;
    localparam logic [7:0] TIMER2_ADDR     = 8'h03;
    localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

    localparam int unsigned STATUS_IRQ_BIT = 7;
    localparam int unsigned STATUS_FT1_BIT = 6;
    localparam int unsigned STATUS_FT2_BIT = 5;

endpackage

// File: rtl/opl3_timer_channel.sv
// One OPL3 timer: prescaler of DIV sample pulses feeding an 8-bit up-counter.
// Emits a combinational one-cycle overflow pulse on the tick that wraps 0xFF.
module opl3_timer_channel #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] preset,
    input  logic       start,
    input  logic       sample_clk_en,
    output logic       overflow
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          running;
    logic [7:0]    counter;
    logic [PW-1:0] prescaler;
    logic          load;
    logic          tick;

    // A rising start loads and suppresses any tick in that same cycle.
    assign load     = start && !running;
    assign tick     = start && running && sample_clk_en && (prescaler == PW'(DIV - 1));
    assign overflow = tick && (counter == 8'hFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            running   <= 1'b0;
            counter   <= '0;
            prescaler <= '0;
        end else begin
            running <= start;
            if (load) begin
                counter   <= preset;
                prescaler <= '0;
            end else if (tick) begin
                prescaler <= '0;
                counter   <= (counter == 8'hFF) ? preset : counter + 8'd1;
            end else if (start && running && sample_clk_en) begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2 with sticky flags, masks, status byte and active-low IRQ.
// Build option OPL3_TIMERS_OPL2_STATUS_EN: status[2:1] read as 2'b11 for OPL2 detection code.
module opl3_timers
    import opl3_pkg::*;
#(
    parameter int TIMER1_DIV = 4,
    parameter int TIMER2_DIV = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  opl3_reg_wr_t opl3_reg_wr,
    input  logic         sample_clk_en,
    input  logic         force_timer_overflow,
    output logic [7:0]   status,
    output logic         irq_n
);
    logic [7:0] t1_preset, t2_preset;
    logic       st1, st2, mask1, mask2;
    logic       ft1, ft2, irq_q, irq_n_q;
    logic       bank0_wr, ctrl_wr, rst_wr, ctrl_upd;
    logic       st1_next, st2_next, ft1_next, ft2_next;
    logic       ovf1, ovf2;
    logic       unused_ctrl_bits;

    assign bank0_wr = opl3_reg_wr.valid && !opl3_reg_wr.bank_num;
    assign ctrl_wr  = bank0_wr && (opl3_reg_wr.address == TIMER_CTRL_ADDR);
    assign rst_wr   = ctrl_wr && opl3_reg_wr.data[7];
    assign ctrl_upd = ctrl_wr && !opl3_reg_wr.data[7];
    assign unused_ctrl_bits = ^opl3_reg_wr.data[4:2];

    // Channels see the start bit as it will be after this write so the load lands on the write edge.
    assign st1_next = ctrl_upd ? opl3_reg_wr.data[0] : st1;
    assign st2_next = ctrl_upd ? opl3_reg_wr.data[1] : st2;

    opl3_timer_channel #(.DIV(TIMER1_DIV)) u_timer1 (
        .clk           (clk),
        .reset         (reset),
        .preset        (t1_preset),
        .start         (st1_next),
        .sample_clk_en (sample_clk_en),
        .overflow      (ovf1)
    );

    opl3_timer_channel #(.DIV(TIMER2_DIV)) u_timer2 (
        .clk           (clk),
        .reset         (reset),
        .preset        (t2_preset),
        .start         (st2_next),
        .sample_clk_en (sample_clk_en),
        .overflow      (ovf2)
    );

    assign ft1_next = rst_wr ? 1'b0 : (ft1 || (!mask1 && (ovf1 || force_timer_overflow)));
    assign ft2_next = rst_wr ? 1'b0 : (ft2 || (!mask2 && (ovf2 || force_timer_overflow)));

    always_ff @(posedge clk) begin
        if (reset) begin
            t1_preset <= '0;
            t2_preset <= '0;
            st1       <= 1'b0;
            st2       <= 1'b0;
            mask1     <= 1'b0;
            mask2     <= 1'b0;
            ft1       <= 1'b0;
            ft2       <= 1'b0;
            irq_q     <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            if (bank0_wr && opl3_reg_wr.address == TIMER1_ADDR) t1_preset <= opl3_reg_wr.data;
            if (bank0_wr && opl3_reg_wr.address == TIMER2_ADDR) t2_preset <= opl3_reg_wr.data;
            st1 <= st1_next;
            st2 <= st2_next;
            if (ctrl_upd) begin
                mask1 <= opl3_reg_wr.data[6];
                mask2 <= opl3_reg_wr.data[5];
            end
            ft1     <= ft1_next;
            ft2     <= ft2_next;
            irq_q   <= ft1_next || ft2_next;
            irq_n_q <= !(ft1_next || ft2_next);
        end
    end

    always_comb begin
        status                 = '0;
        status[STATUS_IRQ_BIT] = irq_q;
        status[STATUS_FT1_BIT] = ft1;
        status[STATUS_FT2_BIT] = ft2;
`ifdef OPL3_TIMERS_OPL2_STATUS_EN
        status[2:1]            = 2'b11;
`else
        status[4:0]            = '0;
`endif
    end

    assign irq_n = irq_n_q;

endmodule
